mem_lsu: RTL

- Load/store unit: the data-side initiator for the unified `memory` block, which so far is driven only by `fetch` (read-only, `we` tied to 0).
- Accepts one load or store request at a time from the core. Drives the memory read/byte-write interface and returns extended load data or store completion.
- Sits between the execute stage and a second `memory` port (or arbiter), alongside `fetch`.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_align.sv | 29 ++
 rtl/mem_lsu.sv | 84 ++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and access-size decode for mem_lsu
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    return (f3 == F3_B || f3 == F3_BU) ? 4'd1 :
           (f3 == F3_H || f3 == F3_HU) ? 4'd2 :
           (f3 == F3_D) ? 4'd8 : 4'd4;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane mask, store replication, legality check and load extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  mask,
  output logic [63:0] wrep,
  output logic        err,
  output logic [63:0] ldata
);
  logic [3:0]  n;
  logic [63:0] sh;
  logic        sx;
  assign n     = size_bytes(funct3);
  assign err   = (we ? funct3[2] : funct3 == 3'b111) | (|({1'b0, off} & (n - 4'd1)));
  assign mask  = (8'hFF >> (4'd8 - n)) << off;
  assign wrep  = n == 4'd1 ? {8{wdata[7:0]}} :
                 n == 4'd2 ? {4{wdata[15:0]}} :
                 n == 4'd4 ? {2{wdata[31:0]}} : wdata;
  assign sh    = rdata >> {off, 3'b000};
  assign sx    = ~funct3[2];
  assign ldata = n == 4'd1 ? {{56{sx & sh[7]}}, sh[7:0]} :
                 n == 4'd2 ? {{48{sx & sh[15]}}, sh[15:0]} :
                 n == 4'd4 ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit driving a word-addressed byte-write memory port
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int XLEN       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic [7:0]            mem_we,
  output logic [63:0]           mem_wdata,
  input  logic [63:0]           mem_rdata
);
  state_t                state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+2:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  idle, acc, err;
  logic [7:0]            mask;
  logic [63:0]           wrep, ldata;
  logic                  unused_addr;
  assign idle        = state == IDLE;
  assign acc         = state == ACCESS && !rst;
  assign unused_addr = ^req_addr[XLEN-1:ADDR_WIDTH+3];
  lsu_align u_align (
    .we     (idle ? req_we : we_q),
    .funct3 (idle ? req_funct3 : f3_q),
    .off    (idle ? req_addr[2:0] : addr_q[2:0]),
    .wdata  (wdata_q),
    .rdata  (mem_rdata),
    .mask   (mask),
    .wrep   (wrep),
    .err    (err),
    .ldata  (ldata)
  );
  assign req_ready  = idle;
  assign resp_valid = state == RESP;
  assign mem_addr   = state == ACCESS ? addr_q[ADDR_WIDTH+2:3] : '0;
  assign mem_re     = acc && !we_q;
  assign mem_we     = (acc && we_q) ? mask : 8'h00;
  assign mem_wdata  = (state == ACCESS && we_q) ? wrep : 64'h0;
  // request capture, access sequencing and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q       <= req_we;
          f3_q       <= req_funct3;
          addr_q     <= req_addr[ADDR_WIDTH+2:0];
          wdata_q    <= req_wdata;
          resp_rdata <= '0;
          resp_err   <= err;
          state      <= err ? RESP : ACCESS;
        end
        ACCESS: state <= we_q ? RESP : WAIT;
        WAIT: begin
          resp_rdata <= ldata;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
